// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_SEND     = 2'd3
  } state_t;

  // Widest requester vector the arbiter supports.
  localparam int MAX_REQ = 8;

  // Burst counter width: enough for a 255-byte burst.
  localparam int CNT_W = 8;

  // Index of the set bit in a one-hot vector; 0 when the vector is empty.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after 'last', with wrap.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  int         pos;
  logic [IDX_W-1:0] idx;
  logic       found;

  // Scan last+1, last+2, ... wrapping at NUM_REQ; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      pos = (int'(last) + off) % NUM_REQ;
      idx = IDX_W'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte serializer among NUM_REQ sources,
// with optional burst lock bounded by MAX_BURST bytes.
//
// state    | meaning
// IDLE     | no owner; pick a winner once the serializer is free
// LOAD     | owner selected; hand its byte to the serializer or drop a withdrawn request
// WAIT_ACK | TxStart issued; waiting for the serializer to report busy
// SEND     | serializer shifting; on completion continue the burst or release
module uart_tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data,
  input  logic [NUM_REQ-1:0]            RequestToSend,
  input  logic [NUM_REQ-1:0]            Lock,
  output logic [NUM_REQ-1:0]            DataReceivedOut,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [DATA_WIDTH-1:0]         TxData,
  output logic                          TxStart,
  input  logic                          TxBusy,
  output logic                          ArbBusy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_t                state, state_d;
  logic [NUM_REQ-1:0]    grant_d, drx_d, pick_grant;
  logic                  pick_valid;
  logic [DATA_WIDTH-1:0] txd_d, sel_data;
  logic                  start_d, sel_rts, sel_lock;
  logic [CNT_W-1:0]      burst_cnt, burst_d;
  logic [IDX_W-1:0]      last_grant, last_d, g_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (RequestToSend),
    .last  (last_grant),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign g_idx   = IDX_W'(onehot_to_idx(MAX_REQ'(Grant)));
  assign sel_rts  = |(RequestToSend & Grant);
  assign sel_lock = |(Lock & Grant);
  assign ArbBusy  = (state != ST_IDLE);

  // Byte of the current owner; Grant is one-hot so at most one slice matches.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (Grant[i]) sel_data = Data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    grant_d = Grant;
    txd_d   = TxData;
    start_d = 1'b0;
    drx_d   = '0;
    burst_d = burst_cnt;
    last_d  = last_grant;
    case (state)
      ST_IDLE: begin
        if (!TxBusy && pick_valid) begin
          grant_d = pick_grant;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!sel_rts) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          txd_d   = sel_data;
          start_d = 1'b1;
          drx_d   = Grant;
          if (burst_cnt < BURST_MAX) burst_d = burst_cnt + 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (TxBusy) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!TxBusy) begin
          if (sel_lock && sel_rts && (burst_cnt < BURST_MAX)) begin
            state_d = ST_LOAD;
          end else begin
            last_d  = g_idx;
            burst_d = '0;
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state           <= ST_IDLE;
      Grant           <= '0;
      TxData          <= '0;
      TxStart         <= 1'b0;
      DataReceivedOut <= '0;
      burst_cnt       <= '0;
      last_grant      <= IDX_W'(NUM_REQ - 1);
    end else begin
      state           <= state_d;
      Grant           <= grant_d;
      TxData          <= txd_d;
      TxStart         <= start_d;
      DataReceivedOut <= drx_d;
      burst_cnt       <= burst_d;
      last_grant      <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: cycle table for single/withdraw/reset cases, then
// requester-model sequences for round-robin, burst lock and burst limit.
module tb_uart_tx_arbiter;

  localparam int NR       = 2;
  localparam int DW       = 8;
  localparam int BUSY_LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]    rts;
  logic [NR-1:0]    lock = '0;

  logic [NR-1:0] drx_a, grant_a, drx_b, grant_b;
  logic [DW-1:0] txd_a, txd_b;
  logic          start_a, start_b, busy_a, busy_b, arb_a, arb_b;

  int cnt_a = 0;
  int cnt_b = 0;

  // Serializer models: busy for BUSY_LEN cycles starting the cycle after TxStart.
  always @(posedge clk) begin
    if (start_a) cnt_a <= BUSY_LEN;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    if (start_b) cnt_b <= BUSY_LEN;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
  end
  assign busy_a = (cnt_a != 0);
  assign busy_b = (cnt_b != 0);

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16)) dut_a (
    .Clock(clk), .Reset(rst_n), .Data(data), .RequestToSend(rts), .Lock(lock),
    .DataReceivedOut(drx_a), .Grant(grant_a), .TxData(txd_a), .TxStart(start_a),
    .TxBusy(busy_a), .ArbBusy(arb_a)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(3)) dut_b (
    .Clock(clk), .Reset(rst_n), .Data(data), .RequestToSend(rts), .Lock(lock),
    .DataReceivedOut(drx_b), .Grant(grant_b), .TxData(txd_b), .TxStart(start_b),
    .TxBusy(busy_b), .ArbBusy(arb_b)
  );

  // Stimulus source select: table-driven or requester model.
  logic          use_model = 1'b0;
  logic [NR-1:0] tab_rts   = '0;
  logic [15:0]   tab_data  = '0;
  logic          sel_b     = 1'b0;

  logic [7:0] q0 [8];
  logic [7:0] q1 [8];
  int         len0 = 0, len1 = 0;
  int         head0 = 0, head1 = 0;
  logic [1:0] pop_pend = '0;

  assign rts  = use_model ? {head1 < len1, head0 < len0} : tab_rts;
  assign data = use_model ? {(head1 < len1) ? q1[head1[2:0]] : 8'h00,
                             (head0 < len0) ? q0[head0[2:0]] : 8'h00} : tab_data;

  // Requester model: present the next byte the cycle after DataReceivedOut.
  always @(negedge clk) begin
    if (!rst_n) begin
      head0    = 0;
      head1    = 0;
      pop_pend = '0;
    end else begin
      if (pop_pend[0]) head0 = head0 + 1;
      if (pop_pend[1]) head1 = head1 + 1;
      pop_pend = sel_b ? drx_b : drx_a;
    end
  end

  typedef struct packed {
    logic [7:0] txd;
    logic [1:0] drx;
    logic [1:0] grant;
  } ev_t;
  ev_t ev_q[$];

  // Log every TxStart of the selected DUT.
  always @(negedge clk) begin
    if (rst_n && (sel_b ? start_b : start_a))
      ev_q.push_back(sel_b ? ev_t'{txd_b, drx_b, grant_b} : ev_t'{txd_a, drx_a, grant_a});
  end

  typedef struct {
    logic       rst;
    logic [1:0] rts;
    logic [1:0] grant;
    logic       start;
    logic [1:0] drx;
    logic       arb;
    logic [7:0] txd;
  } vec_t;
  vec_t tab [22];

  int checks = 0;
  int miscompares = 0;
  int base = 0;
  logic [7:0] exp_d [8];
  logic [1:0] exp_g [8];

  task automatic wait_events(input string name, input int n);
    int cyc;
    cyc = 0;
    while ((ev_q.size() - base) < n && cyc < 1500) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if ((ev_q.size() - base) < n) begin
      $display("FAIL %s timeout: got %0d bytes, required %0d", name, ev_q.size() - base, n);
      miscompares++;
    end
  endtask

  task automatic check_seq(input string name, input int n);
    wait_events(name, n);
    repeat (40) @(negedge clk);
    checks++;
    if ((ev_q.size() - base) != n) begin
      $display("FAIL %s count: got %0d bytes, required %0d", name, ev_q.size() - base, n);
      miscompares++;
    end
    for (int i = 0; i < n; i++) begin
      if (base + i < ev_q.size()) begin
        checks++;
        if (ev_q[base+i].txd !== exp_d[i] || ev_q[base+i].drx !== exp_g[i] ||
            ev_q[base+i].grant !== exp_g[i]) begin
          $display("FAIL %s byte%0d: got txd=%h drx=%b grant=%b, required txd=%h src=%b",
                   name, i, ev_q[base+i].txd, ev_q[base+i].drx, ev_q[base+i].grant,
                   exp_d[i], exp_g[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic start_seq(input logic sb, input logic [1:0] lk);
    @(negedge clk);
    rst_n     = 1'b0;
    use_model = 1'b1;
    sel_b     = sb;
    lock      = lk;
    len0      = 0;
    len1      = 0;
    repeat (2) @(negedge clk);
    base = ev_q.size();
  endtask

  initial begin
    //          rst   rts    grant  st    drx    arb   txd
    tab[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tab[1]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 8'h00};
    tab[2]  = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 8'hA5};
    tab[3]  = '{1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5};
    tab[4]  = '{1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5};
    tab[5]  = '{1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5};
    tab[6]  = '{1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5};
    tab[7]  = '{1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5};
    tab[8]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5};
    tab[9]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5};
    tab[10] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5};
    tab[11] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5};
    tab[12] = '{1'b1, 2'b11, 2'b10, 1'b0, 2'b00, 1'b1, 8'hA5};
    tab[13] = '{1'b1, 2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 8'h3C};
    tab[14] = '{1'b1, 2'b01, 2'b10, 1'b0, 2'b00, 1'b1, 8'h3C};
    tab[15] = '{1'b1, 2'b01, 2'b10, 1'b0, 2'b00, 1'b1, 8'h3C};
    tab[16] = '{1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tab[17] = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tab[18] = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tab[19] = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 8'h00};
    tab[20] = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 8'hA5};
    tab[21] = '{1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5};

    tab_data = 16'h3CA5;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst_n   = tab[i].rst;
      tab_rts = tab[i].rts;
      @(posedge clk);
      #1;
      checks++;
      if (grant_a !== tab[i].grant || start_a !== tab[i].start || drx_a !== tab[i].drx ||
          arb_a !== tab[i].arb || txd_a !== tab[i].txd) begin
        $display("FAIL vec%0d: got grant=%b start=%b drx=%b arb=%b txd=%h, required grant=%b start=%b drx=%b arb=%b txd=%h",
                 i, grant_a, start_a, drx_a, arb_a, txd_a,
                 tab[i].grant, tab[i].start, tab[i].drx, tab[i].arb, tab[i].txd);
        miscompares++;
      end
    end

    // Round-robin, no lock: 0,1,0,1.
    start_seq(1'b0, 2'b00);
    q0[0] = 8'h10; q0[1] = 8'h12; len0 = 2;
    q1[0] = 8'h20; q1[1] = 8'h22; len1 = 2;
    @(negedge clk); rst_n = 1'b1;
    exp_d[0] = 8'h10; exp_g[0] = 2'b01;
    exp_d[1] = 8'h20; exp_g[1] = 2'b10;
    exp_d[2] = 8'h12; exp_g[2] = 2'b01;
    exp_d[3] = 8'h22; exp_g[3] = 2'b10;
    check_seq("round_robin", 4);

    // Burst lock on requester 1; requester 0 arrives after the first byte.
    start_seq(1'b0, 2'b10);
    q1[0] = 8'h11; q1[1] = 8'h22; q1[2] = 8'h33; q1[3] = 8'h44; q1[4] = 8'h55; len1 = 5;
    @(negedge clk); rst_n = 1'b1;
    wait_events("burst_lock_first", 1);
    q0[0] = 8'h77; len0 = 1;
    exp_d[0] = 8'h11; exp_g[0] = 2'b10;
    exp_d[1] = 8'h22; exp_g[1] = 2'b10;
    exp_d[2] = 8'h33; exp_g[2] = 2'b10;
    exp_d[3] = 8'h44; exp_g[3] = 2'b10;
    exp_d[4] = 8'h55; exp_g[4] = 2'b10;
    exp_d[5] = 8'h77; exp_g[5] = 2'b01;
    check_seq("burst_lock", 6);

    // Burst limit of 3 on the second instance.
    start_seq(1'b1, 2'b01);
    q0[0] = 8'hA1; q0[1] = 8'hA2; q0[2] = 8'hA3; q0[3] = 8'hA4; q0[4] = 8'hA5; len0 = 5;
    q1[0] = 8'hB1; len1 = 1;
    @(negedge clk); rst_n = 1'b1;
    exp_d[0] = 8'hA1; exp_g[0] = 2'b01;
    exp_d[1] = 8'hA2; exp_g[1] = 2'b01;
    exp_d[2] = 8'hA3; exp_g[2] = 2'b01;
    exp_d[3] = 8'hB1; exp_g[3] = 2'b10;
    exp_d[4] = 8'hA4; exp_g[4] = 2'b01;
    exp_d[5] = 8'hA5; exp_g[5] = 2'b01;
    check_seq("burst_limit", 6);

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte serializer (TxD path) among NUM_REQ byte sources, e.g. the sample FIFO, the echo path and status/ADC reporting.
- Arbitration is round-robin, with optional burst lock so a multi-byte packet is not interleaved with other sources.
- Sits between the requesters' RequestToSend/DataReceived handshake and the serializer's TxStart/TxBusy handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 8, bits per transmitted byte
- MAX_BURST, 16, max consecutive bytes one locked requester may send before re-arbitration (1..255)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- Data  in  NUM_REQ*DATA_WIDTH  concatenated bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- RequestToSend  in  NUM_REQ  per-requester byte-valid
- Lock  in  NUM_REQ  per-requester: keep grant for the next byte if RequestToSend is still high
- DataReceivedOut  out  NUM_REQ  one-cycle pulse: byte from requester i was captured
- Grant  out  NUM_REQ  one-hot current owner; 0 when idle
- TxData  out  DATA_WIDTH  byte to serializer
- TxStart  out  1  one-cycle start pulse to serializer
- TxBusy  in  1  serializer busy (high from the cycle after TxStart until the stop bit ends)
- ArbBusy  out  1  high whenever state != IDLE

Behaviour:
- Reset (Reset==0 at posedge):
  - State=IDLE; Grant=0; TxData=0; TxStart=0; DataReceivedOut=0; BurstCnt=0; LastGrant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transfer abandons the transfer; the serializer is not told, and the arbiter waits for TxBusy==0 before the next TxStart.
- States: IDLE, LOAD, WAIT_ACK, SEND.
- IDLE:
  - If TxBusy==0 and any RequestToSend bit is high, pick the first set bit scanning from LastGrant+1 upward with wrap at NUM_REQ.
  - Register the winner in Grant (one-hot) and go to LOAD.
  - No request: stay in IDLE.
- LOAD:
  - If RequestToSend[g]==0 (request withdrawn), Grant<=0 and go to IDLE; no pulse, LastGrant unchanged.
  - Otherwise, for exactly one cycle: TxData<=Data[g]; TxStart=1; DataReceivedOut[g]=1; BurstCnt<=BurstCnt+1 (saturating at MAX_BURST). Then go to WAIT_ACK.
  - Latency: first TxStart occurs 2 cycles after RequestToSend rises in IDLE.
- WAIT_ACK: wait for TxBusy==1, then go to SEND. TxData is held stable.
- SEND: wait for TxBusy==0, then:
  - if Lock[g] && RequestToSend[g] && BurstCnt<MAX_BURST, go to LOAD with the same Grant;
  - else LastGrant<=g; BurstCnt<=0; Grant<=0; go to IDLE.
- Requester rules:
  - Deassert RequestToSend, or present the next byte, in the cycle after DataReceivedOut.
  - Data must be stable while RequestToSend is high.
  - The arbiter never samples a requester's RequestToSend earlier than 2 cycles after its DataReceivedOut.
- Simultaneous events:
  - A new request arriving while another is granted waits; it is never lost (level-sensitive).
  - Lock on a non-granted requester has no effect.
  - Lock dropping during SEND ends the burst at the SEND exit.
- Burst limit: after MAX_BURST bytes the grant is released even if Lock stays high. If other requests are pending they win next; if none are pending, the same requester re-wins through IDLE, costing 1 extra cycle.
- Fairness: any requester holding RequestToSend high is served within (NUM_REQ-1)*MAX_BURST bytes.
- Grant is one-hot or zero at all times; DataReceivedOut has at most one bit set and pulses only in LOAD.

Decomposition:
- Shared package tx_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_WAIT_ACK=2'd2, ST_SEND=2'd3
  - function for the one-hot-to-index conversion
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_REQ], last[log2 NUM_REQ].
  - Outputs: one-hot grant, valid.

Test Plan:
- Single request: req0 RTS=1, Data0=8'hA5, TxBusy model 10 cycles → TxStart at cycle +2 with TxData=A5; DataReceivedOut=01 in the same cycle; Grant returns to 0 after TxBusy falls.
- Round-robin: both RTS held high, Lock=0, 4 bytes → grant order 0,1,0,1; each DataReceivedOut pulse matches the TxData source.
- Burst lock: req1 Lock=1 and RTS for 5 bytes (11,22,33,44,55) while req0 RTS is high → TxData sequence 11..55 uninterrupted, then req0 is served.
- Burst limit: MAX_BURST=3, req0 Lock=1 with RTS always high, req1 pending → req0 sends 3 bytes, req1 sends 1, then req0 resumes.
- Withdrawn request: req0 RTS pulses high for 1 cycle in IDLE → no TxStart, no DataReceivedOut, ArbBusy high for exactly 1 cycle.
- Reset mid-SEND: Reset=0 for 1 cycle while TxBusy=1 → all outputs 0 next cycle; the next TxStart is not issued until TxBusy==0.
